regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: register width in bits.
REQ-002 SHALL have parameter NREG, default 32: register count, power of two ≥ 2; AW = clog2(NREG).
REQ-003 SHALL have parameter NRD, default 2: number of read ports, 1..4.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 rs_addr  input  NRD*AW  read addresses; port k in slice [k*AW +: AW].
REQ-007 rs_data  output  NRD*XLEN  read data, combinational; port k in slice [k*XLEN +: XLEN].
REQ-008 rs_busy  output  NRD  per-port pending-write flag, combinational.
REQ-009 wr0_en, wr1_en  input  1 each  write enables; port 1 is the younger instruction.
REQ-010 wr0_addr, wr1_addr  input  AW each  write addresses.
REQ-011 wr0_data, wr1_data  input  XLEN each  write data.
REQ-012 iss_en  input  1  issue strobe; marks iss_addr busy.
REQ-013 iss_addr  input  AW  destination register of the issuing instruction.
REQ-014 busy_cnt  output  clog2(NREG)+1  number of registers currently marked busy, registered.

Function
REQ-015 Register 0 SHALL always read 0, SHALL ignore writes, and SHALL never be marked busy.
REQ-016 Writes SHALL update the array on the rising edge when wrN_en=1 and wrN_addr≠0.
REQ-017 On a same-address dual write, wr1_data SHALL be stored.
REQ-018 A read with rs_addr≠0 that matches an enabled write address SHALL return that write's data in the same cycle, with wr1 taking priority over wr0.
REQ-019 Otherwise a read SHALL return the array contents, or 0 when the address is 0.
REQ-020 An enabled write with addr≠0 SHALL clear busy[addr] at the edge.
REQ-021 An iss_en with iss_addr≠0 SHALL set busy[iss_addr] at the edge.
REQ-022 When a set and a clear hit the same register in the same cycle, the set SHALL win.
REQ-023 rs_busy[k] SHALL equal busy[rs_addr_k] masked off by any same-cycle enabled write to that address, so the bypass and busy views agree.
REQ-024 The iss_en of the current cycle SHALL NOT affect rs_busy until the next cycle.
REQ-025 busy_cnt SHALL equal the popcount of the busy vector after each edge.
REQ-026 busy_cnt SHALL be updated incrementally: +1 for a set of a non-busy register, −1 for each clear of a busy register not also being set, with a dual clear of the same register counting once.
REQ-027 Issue to an already-busy register SHALL leave busy_cnt unchanged.
REQ-028 Writes to non-busy registers SHALL be legal: data SHALL be stored and the count SHALL be unchanged.

Reset
REQ-029 While rst_n=0, all registers SHALL be 0, all busy bits 0 and busy_cnt 0, asynchronously.
REQ-030 Writes or issues asserted during reset SHALL be discarded.
REQ-031 The first edge after deassertion SHALL process inputs normally.

Structure
REQ-032 Package riscv_rf_pkg SHALL hold the XLEN/NREG/NRD defaults and the register-0 address constant.
REQ-033 The busy vector and busy_cnt SHALL live in sub-module rf_scoreboard (ports: clk, rst_n, set_en/set_addr, two clear en/addr pairs, busy vector, busy_cnt).
REQ-034 The data array and bypass muxes SHALL remain in regfile_mp.

Verification
REQ-035 Reset, then wr0 x5=0xDEADBEEF, then read x5 next cycle -> rs_data=0xDEADBEEF, rs_busy=0.
REQ-036 Same cycle: wr0 x7=0x11111111 and wr1 x7=0x22222222; read x7 in that cycle -> 0x22222222; next cycle -> 0x22222222.
REQ-037 Issue x3 -> next cycle rs_busy=1 and busy_cnt=1; wr1 x3=0xA5A5A5A5 in the same cycle a port reads x3 -> rs_data=0xA5A5A5A5, rs_busy=0; busy_cnt=0 after the edge.
REQ-038 Issue x9 and wr0 x9 in the same cycle while x9 is busy -> x9 stays busy and busy_cnt is unchanged.
REQ-039 wr0 x0=0xFFFFFFFF and issue x0 -> x0 reads 0, rs_busy=0, busy_cnt=0.
REQ-040 Issue x1..x4 over 4 cycles, then assert rst_n=0 mid-cycle -> busy_cnt=0, all rs_data=0, all rs_busy=0 immediately, before any clock edge.

Source files
------------

// File: rtl/riscv_rf_pkg.sv
// ---------------------------------------------------------------------------
// riscv_rf_pkg
// Shared defaults for the multi-port register file and its busy scoreboard.
//   XLEN_DEF  : default register width in bits
//   NREG_DEF  : default register count (power of two)
//   NRD_DEF   : default number of read ports
//   REG0_ADDR : architectural zero register (reads 0, never written/busy)
// ---------------------------------------------------------------------------
package riscv_rf_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREG_DEF  = 32;
    localparam int unsigned NRD_DEF   = 2;
    localparam int unsigned REG0_ADDR = 0;

endpackage : riscv_rf_pkg

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// Tracks which registers have an in-flight producer (busy) and keeps a
// registered count of busy registers, updated incrementally.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   set_en, set_addr     : issue strobe, marks set_addr busy at the edge
//   clr0_en, clr0_addr   : write-back port 0, clears busy at the edge
//   clr1_en, clr1_addr   : write-back port 1, clears busy at the edge
//   busy                 : busy vector (bit per register, bit 0 always 0)
//   busy_cnt             : popcount of busy, registered
// ---------------------------------------------------------------------------
module rf_scoreboard
    import riscv_rf_pkg::*;
#(
    parameter int NREG = NREG_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      set_en,
    input  logic [$clog2(NREG)-1:0]   set_addr,
    input  logic                      clr0_en,
    input  logic [$clog2(NREG)-1:0]   clr0_addr,
    input  logic                      clr1_en,
    input  logic [$clog2(NREG)-1:0]   clr1_addr,
    output logic [NREG-1:0]           busy,
    output logic [$clog2(NREG):0]     busy_cnt
);

    localparam int AW = $clog2(NREG);
    localparam int CW = AW + 1;

    logic            set_v, clr0_v, clr1_v;
    logic            inc, dec0, dec1;
    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Register 0 is filtered here so it can never become busy.
    assign set_v  = set_en  && (set_addr  != AW'(REG0_ADDR));
    assign clr0_v = clr0_en && (clr0_addr != AW'(REG0_ADDR));
    assign clr1_v = clr1_en && (clr1_addr != AW'(REG0_ADDR));

    always_comb begin
        busy_d = busy_q;
        // Clears first so a same-register set overrides them.
        if (clr0_v) busy_d[clr0_addr] = 1'b0;
        if (clr1_v) busy_d[clr1_addr] = 1'b0;
        if (set_v)  busy_d[set_addr]  = 1'b1;
    end

    // Count bookkeeping: a clear only counts if it actually drops a busy bit
    // that is not re-set this cycle; a dual clear of one register counts once.
    always_comb begin
        inc  = set_v && !busy_q[set_addr];
        dec0 = clr0_v && busy_q[clr0_addr]
               && !(set_v && (set_addr == clr0_addr));
        dec1 = clr1_v && busy_q[clr1_addr]
               && !(set_v && (set_addr == clr1_addr))
               && !(clr0_v && (clr0_addr == clr1_addr));
        cnt_d = cnt_q + CW'(inc) - CW'(dec0) - CW'(dec1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = cnt_q;

endmodule : rf_scoreboard

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Multi-read, dual-write register file with write-to-read bypass and a busy
// scoreboard. Register 0 is hard-wired to zero.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   rs_addr  [NRD*AW]           : read addresses, port k at [k*AW +: AW]
//   rs_data  [NRD*XLEN]         : read data (combinational, bypassed)
//   rs_busy  [NRD]              : pending-write flag per read port
//   wr0_*/wr1_*                 : write ports, wr1 is the younger instruction
//   iss_en, iss_addr            : issue strobe marking a destination busy
//   busy_cnt                    : registered count of busy registers
// ---------------------------------------------------------------------------
module regfile_mp
    import riscv_rf_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = NRD_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NRD*$clog2(NREG)-1:0]     rs_addr,
    output logic [NRD*XLEN-1:0]             rs_data,
    output logic [NRD-1:0]                  rs_busy,
    input  logic                            wr0_en,
    input  logic [$clog2(NREG)-1:0]         wr0_addr,
    input  logic [XLEN-1:0]                 wr0_data,
    input  logic                            wr1_en,
    input  logic [$clog2(NREG)-1:0]         wr1_addr,
    input  logic [XLEN-1:0]                 wr1_data,
    input  logic                            iss_en,
    input  logic [$clog2(NREG)-1:0]         iss_addr,
    output logic [$clog2(NREG):0]           busy_cnt
);

    localparam int AW = $clog2(NREG);

    logic            wr0_v, wr1_v;
    logic [NREG-1:0] busy;
    logic [XLEN-1:0] regs_q [NREG];

    assign wr0_v = wr0_en && (wr0_addr != AW'(REG0_ADDR));
    assign wr1_v = wr1_en && (wr1_addr != AW'(REG0_ADDR));

    // One flop row per register; row 0 never sees a valid write so it
    // stays at its reset value of zero.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_q[gi] <= '0;
                end else if (wr1_v && (wr1_addr == AW'(gi))) begin
                    regs_q[gi] <= wr1_data;
                end else if (wr0_v && (wr0_addr == AW'(gi))) begin
                    regs_q[gi] <= wr0_data;
                end
            end
        end
    endgenerate

    // Read ports: bypass from the in-flight writes (wr1 wins), and mask the
    // busy flag by the same hits so data and busy views stay consistent.
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] addr;
            logic          hit0, hit1;

            assign addr = rs_addr[gi*AW +: AW];
            assign hit0 = wr0_v && (wr0_addr == addr);
            assign hit1 = wr1_v && (wr1_addr == addr);

            always_comb begin
                if (addr == AW'(REG0_ADDR)) begin
                    rs_data[gi*XLEN +: XLEN] = '0;
                end else if (hit1) begin
                    rs_data[gi*XLEN +: XLEN] = wr1_data;
                end else if (hit0) begin
                    rs_data[gi*XLEN +: XLEN] = wr0_data;
                end else begin
                    rs_data[gi*XLEN +: XLEN] = regs_q[addr];
                end
            end

            assign rs_busy[gi] = busy[addr] && !hit0 && !hit1;
        end
    endgenerate

    rf_scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (iss_en),
        .set_addr  (iss_addr),
        .clr0_en   (wr0_en),
        .clr0_addr (wr0_addr),
        .clr1_en   (wr1_en),
        .clr1_addr (wr1_addr),
        .busy      (busy),
        .busy_cnt  (busy_cnt)
    );

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
// Directed bench for regfile_mp with default parameters (32x32, 2 read ports).
// Inputs change just after a rising edge; combinational outputs are checked
// 1 ns after the inputs settle, registered outputs 1 ns after the edge.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rs_addr;
    logic [63:0] rs_data;
    logic [1:0]  rs_busy;
    logic        wr0_en, wr1_en, iss_en;
    logic [4:0]  wr0_addr, wr1_addr, iss_addr;
    logic [31:0] wr0_data, wr1_data;
    logic [5:0]  busy_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_mp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs_addr  (rs_addr),
        .rs_data  (rs_data),
        .rs_busy  (rs_busy),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) begin
            $display("ok   %-14s observed=%h expected=%h", tag, obs, exp);
        end else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_en = 1'b0; wr1_en = 1'b0; iss_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rs_addr = {a1, a0};
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        wr0_addr = '0; wr1_addr = '0; iss_addr = '0;
        wr0_data = '0; wr1_data = '0;
        rd(5'd0, 5'd0);

        // Reset state
        #3;
        chk("rst_cnt",   32'(busy_cnt), 32'd0);
        chk("rst_busy",  32'(rs_busy),  32'd0);
        #9 rst_n = 1'b1;
        tick();

        // Plain write, read back next cycle; count stays 0 (non-busy write)
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        tick();
        idle(); rd(5'd5, 5'd0); #1;
        chk("x5_data",  rs_data[31:0], 32'hDEADBEEF);
        chk("x5_busy",  32'(rs_busy[0]), 32'd0);
        chk("x5_cnt",   32'(busy_cnt), 32'd0);

        // Dual write to x7: wr1 wins on bypass and in the array
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11111111;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22222222;
        rd(5'd5, 5'd7); #1;
        chk("x7_byp",   rs_data[63:32], 32'h22222222);
        chk("x5_hold",  rs_data[31:0],  32'hDEADBEEF);
        tick();
        idle(); #1;
        chk("x7_arr",   rs_data[63:32], 32'h22222222);

        // Issue x3: not visible as busy in the issue cycle, busy next cycle
        iss_en = 1'b1; iss_addr = 5'd3; rd(5'd3, 5'd0); #1;
        chk("x3_iss0",  32'(rs_busy[0]), 32'd0);
        tick();
        idle(); #1;
        chk("x3_busy",  32'(rs_busy[0]), 32'd1);
        chk("x3_cnt1",  32'(busy_cnt), 32'd1);
        // wr1 write-back of x3 bypasses and masks busy
        wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'hA5A5A5A5; #1;
        chk("x3_byp",   rs_data[31:0], 32'hA5A5A5A5);
        chk("x3_bmask", 32'(rs_busy[0]), 32'd0);
        tick();
        idle(); #1;
        chk("x3_cnt0",  32'(busy_cnt), 32'd0);
        chk("x3_arr",   rs_data[31:0], 32'hA5A5A5A5);

        // x9 busy; issue + write x9 together -> stays busy, count unchanged
        iss_en = 1'b1; iss_addr = 5'd9;
        tick();
        idle(); rd(5'd9, 5'd0); #1;
        chk("x9_cnt1",  32'(busy_cnt), 32'd1);
        iss_en = 1'b1; iss_addr = 5'd9;
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h00000099;
        tick();
        idle(); #1;
        chk("x9_busy",  32'(rs_busy[0]), 32'd1);
        chk("x9_cnt",   32'(busy_cnt), 32'd1);
        chk("x9_data",  rs_data[31:0], 32'h00000099);
        // Dual clear of the same busy register counts once
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h0000AAAA;
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h0000BBBB;
        tick();
        idle(); #1;
        chk("x9_dclr",  32'(busy_cnt), 32'd0);
        chk("x9_dbusy", 32'(rs_busy[0]), 32'd0);
        chk("x9_ddat",  rs_data[31:0], 32'h0000BBBB);

        // Set and clear of a non-busy register in one cycle: set wins
        iss_en = 1'b1; iss_addr = 5'd12;
        wr1_en = 1'b1; wr1_addr = 5'd12; wr1_data = 32'h12121212;
        tick();
        idle(); rd(5'd12, 5'd0); #1;
        chk("x12_cnt",  32'(busy_cnt), 32'd1);
        chk("x12_busy", 32'(rs_busy[0]), 32'd1);
        wr0_en = 1'b1; wr0_addr = 5'd12; wr0_data = 32'h0;
        tick();
        idle(); #1;
        chk("x12_clr",  32'(busy_cnt), 32'd0);

        // Register 0: writes and issues ignored
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF;
        iss_en = 1'b1; iss_addr = 5'd0; rd(5'd0, 5'd0); #1;
        chk("x0_byp",   rs_data[31:0], 32'd0);
        chk("x0_busyc", 32'(rs_busy), 32'd0);
        tick();
        idle(); #1;
        chk("x0_data",  rs_data[63:32], 32'd0);
        chk("x0_busy",  32'(rs_busy), 32'd0);
        chk("x0_cnt",   32'(busy_cnt), 32'd0);

        // Issue x1..x4, then asynchronous reset mid-cycle
        for (int r = 1; r <= 4; r++) begin
            iss_en = 1'b1; iss_addr = 5'(r);
            tick();
        end
        idle(); rd(5'd1, 5'd7); #1;
        chk("m_cnt4",   32'(busy_cnt), 32'd4);
        chk("m_busy1",  32'(rs_busy[0]), 32'd1);
        chk("m_x7",     rs_data[63:32], 32'h22222222);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_cnt",   32'(busy_cnt), 32'd0);
        chk("ar_busy",  32'(rs_busy), 32'd0);
        chk("ar_x7",    rs_data[63:32], 32'd0);
        rd(5'd5, 5'd3); #1;
        chk("ar_x5x3",  32'(rs_data[31:0] | rs_data[63:32]), 32'd0);

        // Writes/issues during reset are discarded
        wr0_en = 1'b1; wr0_addr = 5'd6; wr0_data = 32'h66666666;
        iss_en = 1'b1; iss_addr = 5'd6;
        tick();
        idle(); rd(5'd6, 5'd0);
        #2 rst_n = 1'b1;
        #1;
        chk("rd_x6",    rs_data[31:0], 32'd0);
        chk("rd_busy",  32'(rs_busy[0]), 32'd0);
        chk("rd_cnt",   32'(busy_cnt), 32'd0);

        // First edge after release is a normal edge
        tick();
        iss_en = 1'b1; iss_addr = 5'd6;
        wr1_en = 1'b1; wr1_addr = 5'd8; wr1_data = 32'h88888888;
        tick();
        idle(); rd(5'd6, 5'd8); #1;
        chk("pr_cnt",   32'(busy_cnt), 32'd1);
        chk("pr_busy",  32'(rs_busy[0]), 32'd1);
        chk("pr_x8",    rs_data[63:32], 32'h88888888);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_regfile_mp
